unit_pkt_rx: RTL and testbench

UNIT_PKT_RX -- requirements
Module: unit_pkt_rx

---
 rtl/unit_pkt_rx_pkg.sv | 30 +++
 rtl/unit_pkt_rx_pack.sv | 83 ++++++++
 rtl/unit_pkt_rx.sv | 192 +++++++++++++++++++
 tb/tb_unit_pkt_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unit_pkt_rx_pkg.sv
// rtl/unit_pkt_rx_pkg.sv - receive-side packet constants, FSM states and key length helper
package unit_pkt_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_IDS,
    S_KLEN,
    S_PAD,
    S_KEY,
    S_PEND
  } rx_state_t;

  localparam logic [7:0] HDR_BYTE      = 8'h00;
  localparam logic [2:0] INIT_TAG      = 3'b001;
  localparam logic [4:0] CFG_LAST      = 5'd23;
  localparam logic [4:0] IDS_LAST      = 5'd7;
  localparam logic [4:0] PAD_LAST      = 5'd6;
  localparam logic [4:0] CFG_WORD_BASE = 5'd0;
  localparam int         KEY_BASE_DEF  = 8;

  // key_len=0 means a full-length key; otherwise round the length up to whole words.
  function automatic logic [4:0] key_word_count(input logic [7:0] kl, input int max_len);
    int nbytes;
    if (kl == 8'd0) nbytes = max_len;
    else            nbytes = (((int'(kl) - 1) % max_len) / 4) * 4 + 4;
    return 5'(nbytes / 4);
  endfunction

endpackage

// File: rtl/unit_pkt_rx_pack.sv
// rtl/unit_pkt_rx_pack.sv - byte-to-word LE packer with a one-word hold register
module unit_pkt_rx_pack
  import unit_pkt_rx_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic [4:0]  word_addr,
  input  logic        word_last,
  input  logic        clr,
  input  logic        mem_busy,
  output logic [1:0]  lane,
  output logic        mem_wr_en,
  output logic [4:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic        wr_last,
  output logic        hold_full,
  output logic        afull,
  output logic        overflow
);

  logic [23:0] partial;
  logic [31:0] hold_data;
  logic [4:0]  hold_addr;
  logic        hold_last;
  logic [31:0] full_word;

  assign full_word = {byte_data, partial};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lane      <= 2'd0;
      partial   <= 24'd0;
      hold_data <= 32'd0;
      hold_addr <= 5'd0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= 5'd0;
      mem_din   <= 32'd0;
      wr_last   <= 1'b0;
      afull     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      wr_last   <= 1'b0;
      overflow  <= 1'b0;
      afull     <= mem_busy | hold_full;
      if (hold_full && !mem_busy) begin
        mem_wr_en <= 1'b1;
        mem_addr  <= hold_addr;
        mem_din   <= hold_data;
        wr_last   <= hold_last;
        hold_full <= 1'b0;
      end
      if (clr) begin
        lane <= 2'd0;
      end else if (byte_valid) begin
        lane <= lane + 2'd1;
        if (lane == 2'd3) begin
          // A word finishing while the previous one is still parked has nowhere to go.
          if (hold_full) begin
            overflow <= 1'b1;
          end else if (!mem_busy) begin
            mem_wr_en <= 1'b1;
            mem_addr  <= word_addr;
            mem_din   <= full_word;
            wr_last   <= word_last;
          end else begin
            hold_full <= 1'b1;
            hold_data <= full_word;
            hold_addr <= word_addr;
            hold_last <= word_last;
          end
        end else begin
          partial[{lane, 3'b000} +: 8] <= byte_data;
        end
      end
    end
  end

endmodule

// File: rtl/unit_pkt_rx.sv
// rtl/unit_pkt_rx.sv - unit packet receiver: parses data/init packets into unit memory and fields
module unit_pkt_rx
  import unit_pkt_rx_pkg::*;
#(
  parameter int WORD_MAX_LEN = 64,
  parameter int KEY_BASE     = KEY_BASE_DEF,
  localparam int KLW         = $clog2(WORD_MAX_LEN + 1)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [7:0]     in_data,
  input  logic           in_ctrl,
  input  logic           in_wr_en,
  output logic           afull,
  output logic           ready,
  output logic           mem_wr_en,
  output logic [4:0]     mem_addr,
  output logic [31:0]    mem_din,
  input  logic           mem_busy,
  output logic [31:0]    cnt,
  output logic [31:0]    salt_len,
  output logic [63:0]    ids,
  output logic [KLW-1:0] key_len,
  output logic           pkt_valid,
  input  logic           pkt_consume,
  output logic           init_valid,
  output logic [4:0]     init_data,
  output logic           err
);

  rx_state_t   state;
  logic [4:0]  byte_idx;
  logic [4:0]  key_words;
  logic [1:0]  lane;
  logic        is_init;
  logic        key_last;
  logic        abort;
  logic        pack_valid;
  logic [4:0]  pack_addr;
  logic        pack_wr_last;
  logic        pack_overflow;
  logic        hold_full;

  // In KEY the byte counter counts whole words; the packer lane supplies the byte offset.
  always_comb begin
    is_init  = in_ctrl && (in_data[2:0] == INIT_TAG);
    key_last = (state == S_KEY) && (lane == 2'd3) && (byte_idx == key_words - 5'd1);
    abort    = 1'b0;
    if (in_wr_en) begin
      case (state)
        S_CFG, S_IDS, S_KLEN: abort = in_ctrl;
        S_PAD:                abort = in_ctrl || (in_data != 8'd0);
        S_KEY:                abort = (in_ctrl != key_last);
        default:              abort = 1'b0;
      endcase
    end
    pack_valid = in_wr_en && !abort && ((state == S_CFG) || (state == S_KEY));
    pack_addr  = (state == S_KEY) ? 5'(KEY_BASE) + byte_idx
                                  : CFG_WORD_BASE + {2'b00, byte_idx[4:2]};
  end

  unit_pkt_rx_pack u_pack (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word_addr  (pack_addr),
    .word_last  (key_last),
    .clr        (abort),
    .mem_busy   (mem_busy),
    .lane       (lane),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .wr_last    (pack_wr_last),
    .hold_full  (hold_full),
    .afull      (afull),
    .overflow   (pack_overflow)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      byte_idx   <= 5'd0;
      key_words  <= 5'd0;
      ready      <= 1'b0;
      pkt_valid  <= 1'b0;
      init_valid <= 1'b0;
      init_data  <= 5'd0;
      err        <= 1'b0;
      cnt        <= 32'd0;
      salt_len   <= 32'd0;
      ids        <= 64'd0;
      key_len    <= '0;
    end else begin
      init_valid <= 1'b0;
      ready      <= (state == S_IDLE) && !pkt_valid;
      if (pack_overflow) err <= 1'b1;
      if (abort) begin
        err      <= 1'b1;
        state    <= S_IDLE;
        byte_idx <= 5'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_wr_en && in_ctrl) begin
              if (in_data == HDR_BYTE) begin
                state    <= S_CFG;
                byte_idx <= 5'd0;
              end else if (is_init) begin
                init_valid <= 1'b1;
                init_data  <= in_data[7:3];
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_CFG: begin
            if (in_wr_en) begin
              if (byte_idx < 5'd4)      cnt[{byte_idx[1:0], 3'b000} +: 8]      <= in_data;
              else if (byte_idx < 5'd8) salt_len[{byte_idx[1:0], 3'b000} +: 8] <= in_data;
              if (byte_idx == CFG_LAST) begin
                state    <= S_IDS;
                byte_idx <= 5'd0;
              end else begin
                byte_idx <= byte_idx + 5'd1;
              end
            end
          end
          S_IDS: begin
            if (in_wr_en) begin
              ids[{byte_idx[2:0], 3'b000} +: 8] <= in_data;
              if (byte_idx == IDS_LAST) begin
                state    <= S_KLEN;
                byte_idx <= 5'd0;
              end else begin
                byte_idx <= byte_idx + 5'd1;
              end
            end
          end
          S_KLEN: begin
            if (in_wr_en) begin
              key_len   <= KLW'(in_data);
              key_words <= key_word_count(in_data, WORD_MAX_LEN);
              state     <= S_PAD;
              byte_idx  <= 5'd0;
            end
          end
          S_PAD: begin
            if (in_wr_en) begin
              if (byte_idx == PAD_LAST) begin
                state    <= S_KEY;
                byte_idx <= 5'd0;
              end else begin
                byte_idx <= byte_idx + 5'd1;
              end
            end
          end
          S_KEY: begin
            if (in_wr_en && (lane == 2'd3)) begin
              if (key_last) begin
                state    <= S_PEND;
                byte_idx <= 5'd0;
              end else begin
                byte_idx <= byte_idx + 5'd1;
              end
            end
          end
          S_PEND: begin
            if (pack_wr_last) pkt_valid <= 1'b1;
            if (in_wr_en) begin
              if (is_init) begin
                init_valid <= 1'b1;
                init_data  <= in_data[7:3];
              end else begin
                err <= 1'b1;
              end
            end
            // ready was low, so a header arriving alongside the consume is dropped above.
            if (pkt_consume) begin
              state     <= S_IDLE;
              pkt_valid <= 1'b0;
              byte_idx  <= 5'd0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unit_pkt_rx.sv
// tb/tb_unit_pkt_rx.sv - directed self-checking bench for unit_pkt_rx
module tb_unit_pkt_rx;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ctrl = 1'b0;
  logic        in_wr_en = 1'b0;
  logic        mem_busy = 1'b0;
  logic        pkt_consume = 1'b0;
  logic        afull, ready, mem_wr_en, pkt_valid, init_valid, err;
  logic [4:0]  mem_addr, init_data;
  logic [31:0] mem_din, cnt, salt_len;
  logic [63:0] ids;
  logic [6:0]  key_len;

  unit_pkt_rx dut (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr_en(in_wr_en),
    .afull(afull), .ready(ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_busy(mem_busy), .cnt(cnt), .salt_len(salt_len), .ids(ids), .key_len(key_len),
    .pkt_valid(pkt_valid), .pkt_consume(pkt_consume), .init_valid(init_valid),
    .init_data(init_data), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  klen;
    logic [31:0] cnt;
    logic [31:0] salt_len;
    logic [63:0] ids;
    int          used;
    logic [7:0]  base;
    int          nkey;
    logic [31:0] exp_w8;
    int          exp_writes;
  } case_t;

  case_t       tbl [6];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  pkt_q [$];
  logic        ctl_q [$];
  logic        busy_drv = 1'b0;
  logic [31:0] mem [32];
  int          nwrites, pv_rises, cyc, last_wr_cyc, pv_rise_cyc;
  logic        pv_q = 1'b0;

  always @(negedge CLK) begin
    cyc++;
    if (mem_wr_en === 1'b1) begin
      mem[mem_addr] = mem_din;
      nwrites++;
      last_wr_cyc = cyc;
    end
    if (pkt_valid && !pv_q) begin
      pv_rise_cyc = cyc;
      pv_rises++;
    end
    pv_q = pkt_valid;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    @(negedge CLK);
    in_data = d; in_ctrl = c; in_wr_en = 1'b1; mem_busy = busy_drv;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge CLK);
      in_wr_en = 1'b0; in_ctrl = 1'b0; mem_busy = busy_drv;
    end
  endtask

  task automatic clear_mon();
    nwrites = 0; pv_rises = 0;
    for (int a = 0; a < 32; a++) mem[a] = 'x;
  endtask

  task automatic push(input logic [7:0] d, input logic c);
    pkt_q.push_back(d); ctl_q.push_back(c);
  endtask

  task automatic build(input case_t c);
    pkt_q.delete(); ctl_q.delete();
    push(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) push(c.cnt[8*i +: 8], 1'b0);
    for (int i = 0; i < 4; i++) push(c.salt_len[8*i +: 8], 1'b0);
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 8; i++) push(c.ids[8*i +: 8], 1'b0);
    push(c.klen, 1'b0);
    for (int i = 0; i < 7; i++) push(8'h00, 1'b0);
    for (int i = 0; i < c.nkey; i++)
      push((i < c.used) ? c.base + 8'(i) : 8'h00, (i == c.nkey - 1));
  endtask

  function automatic logic [31:0] exp_word(input int addr);
    int off;
    off = (addr < 8) ? 1 + 4 * addr : 41 + 4 * (addr - 8);
    return {pkt_q[off+3], pkt_q[off+2], pkt_q[off+1], pkt_q[off]};
  endfunction

  task automatic wait_pv();
    int n = 0;
    while (!pkt_valid && n < 60) begin
      quiet(1);
      n++;
    end
    chk("pv_seen", 64'(pkt_valid), 64'd1);
  endtask

  task automatic consume();
    @(negedge CLK);
    in_wr_en = 1'b0; pkt_consume = 1'b1;
    @(negedge CLK);
    pkt_consume = 1'b0;
    chk("pv_fall", 64'(pkt_valid), 64'd0);
    chk("ready_lag", 64'(ready), 64'd0);
    @(negedge CLK);
    chk("ready_back", 64'(ready), 64'd1);
  endtask

  task automatic run_case(input int k);
    case_t c;
    c = tbl[k];
    build(c);
    clear_mon();
    for (int i = 0; i < pkt_q.size(); i++) send(pkt_q[i], ctl_q[i]);
    wait_pv();
    quiet(1);
    chk("pv_high", 64'(pkt_valid), 64'd1);
    chk("ready_while_pv", 64'(ready), 64'd0);
    chk("pv_latency", 64'(pv_rise_cyc - last_wr_cyc), 64'd1);
    chk("nwrites", 64'(nwrites), 64'(c.exp_writes));
    for (int a = 0; a < 6; a++) chk("cfg_word", 64'(mem[a]), 64'(exp_word(a)));
    for (int n = 0; n < c.nkey / 4; n++) chk("key_word", 64'(mem[8+n]), 64'(exp_word(8 + n)));
    chk("word8", 64'(mem[8]), 64'(c.exp_w8));
    chk("cnt", 64'(cnt), 64'(c.cnt));
    chk("salt_len", 64'(salt_len), 64'(c.salt_len));
    chk("ids", ids, c.ids);
    chk("key_len", 64'(key_len), 64'(c.klen[6:0]));
    chk("err_clean", 64'(err), 64'd0);
    consume();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; in_wr_en = 1'b0; in_ctrl = 1'b0; busy_drv = 1'b0; mem_busy = 1'b0; pkt_consume = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    tbl[0] = '{8'd3,  32'd5000,       32'd8,  64'h0123_4567_89AB_CDEF, 3,  8'h61, 4,  32'h0063_6261, 7};
    tbl[1] = '{8'd0,  32'd1,          32'd16, 64'hFEDC_BA98_7654_3210, 64, 8'h10, 64, 32'h1312_1110, 22};
    tbl[2] = '{8'd12, 32'hDEAD_BEEF,  32'd0,  64'h0000_0000_0000_0001, 12, 8'h20, 12, 32'h2322_2120, 9};
    tbl[3] = '{8'd65, 32'd7,          32'd4,  64'h8000_0000_0000_0000, 4,  8'h30, 4,  32'h3332_3130, 7};
    tbl[4] = '{8'd64, 32'hFFFF_FFFF,  32'd32, 64'hAAAA_5555_AAAA_5555, 64, 8'h40, 64, 32'h4342_4140, 22};
    tbl[5] = '{8'd5,  32'd42,         32'd2,  64'h00FF_00FF_00FF_00FF, 5,  8'h50, 8,  32'h5352_5150, 8};
    clear_mon();

    // reset state
    @(negedge CLK);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_afull", 64'(afull), 64'd0);
    chk("rst_wr", 64'(mem_wr_en), 64'd0);
    chk("rst_pv_err_init", 64'({pkt_valid, err, init_valid}), 64'd0);
    chk("rst_fields", 64'(cnt | salt_len | 32'(key_len)) | ids, 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", 64'(ready), 64'd1);

    for (int k = 0; k < 6; k++) run_case(k);

    // init packet: one-cycle strobe, ready untouched
    send(8'hA9, 1'b1);
    quiet(1);
    chk("init_valid", 64'(init_valid), 64'd1);
    chk("init_data", 64'(init_data), 64'd21);
    chk("init_ready", 64'(ready), 64'd1);
    quiet(1);
    chk("init_pulse_end", 64'(init_valid), 64'd0);
    chk("init_no_err", 64'(err), 64'd0);

    // mem_busy mid-key: one word parked in hold, drained once busy drops
    build(tbl[2]);
    clear_mon();
    for (int i = 0; i <= 44; i++) send(pkt_q[i], ctl_q[i]);
    busy_drv = 1'b1;
    send(pkt_q[45], ctl_q[45]);
    chk("afull_not_yet", 64'(afull), 64'd0);
    send(pkt_q[46], ctl_q[46]);
    chk("afull_rise", 64'(afull), 64'd1);
    send(pkt_q[47], ctl_q[47]);
    send(pkt_q[48], ctl_q[48]);
    quiet(2);
    busy_drv = 1'b0;
    quiet(1);
    chk("busy_no_write", 64'(nwrites), 64'd7);
    chk("afull_hold", 64'(afull), 64'd1);
    quiet(2);
    chk("hold_drained", 64'(nwrites), 64'd8);
    chk("hold_word9", 64'(mem[9]), 64'(exp_word(9)));
    for (int i = 49; i <= 52; i++) send(pkt_q[i], ctl_q[i]);
    wait_pv();
    quiet(1);
    chk("busy_word10", 64'(mem[10]), 64'(exp_word(10)));
    chk("busy_no_err", 64'(err), 64'd0);
    consume();

    // arbiter ignores afull: second word completes while hold is full
    build(tbl[2]);
    clear_mon();
    for (int i = 0; i <= 40; i++) send(pkt_q[i], ctl_q[i]);
    busy_drv = 1'b1;
    for (int i = 41; i <= 48; i++) send(pkt_q[i], ctl_q[i]);
    quiet(3);
    chk("overflow_err", 64'(err), 64'd1);
    chk("overflow_no_key_write", 64'(nwrites), 64'd6);
    chk("overflow_afull", 64'(afull), 64'd1);
    do_reset();

    // unknown ctrl byte in IDLE
    chk("err_cleared", 64'(err), 64'd0);
    send(8'h05, 1'b1);
    quiet(2);
    chk("bad_ctrl_err", 64'(err), 64'd1);
    chk("bad_ctrl_no_init", 64'(init_valid), 64'd0);
    chk("bad_ctrl_ready", 64'(ready), 64'd1);
    do_reset();

    // ctrl on the 10th key byte of a 12-byte key
    build(tbl[2]);
    ctl_q[50] = 1'b1;
    clear_mon();
    for (int i = 0; i <= 50; i++) send(pkt_q[i], ctl_q[i]);
    quiet(2);
    chk("early_ctrl_err", 64'(err), 64'd1);
    chk("early_ctrl_writes", 64'(nwrites), 64'd8);
    quiet(20);
    chk("early_ctrl_no_pv", 64'(pv_rises), 64'd0);
    chk("early_ctrl_idle", 64'(ready), 64'd1);

    // reset pulse at config byte 13
    build(tbl[0]);
    clear_mon();
    for (int i = 0; i <= 13; i++) send(pkt_q[i], ctl_q[i]);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_wr", 64'(mem_wr_en), 64'd0);
    chk("mid_rst_flags", 64'({afull, ready, pkt_valid, init_valid, err}), 64'd0);
    chk("mid_rst_fields", 64'(cnt | salt_len | 32'(key_len)) | ids, 64'd0);
    nw = nwrites;
    in_wr_en = 1'b0; in_ctrl = 1'b0;
    quiet(2);
    @(negedge CLK);
    RST_N = 1'b1;
    chk("mid_rst_ready_low", 64'(ready), 64'd0);
    quiet(1);
    chk("mid_rst_ready_up", 64'(ready), 64'd1);
    chk("mid_rst_no_write", 64'(nwrites), 64'(nw));
    run_case(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
